uart_tx_word_arbiter: RTL and testbench

//  Shares one byte-wide UART transmitter between NREQ word-producing requesters.
//  - Grants requesters round-robin.
//  - Latches the granted BYTES-byte word and serialises it byte by byte into the

---
 rtl/uart_tx_word_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_word_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_arbiter.sv
// Round-robin arbiter that accepts a multi-byte word from one of NREQ requesters
// and feeds it byte by byte into a single byte-wide UART transmitter.
module uart_tx_word_arbiter #(
    parameter int NREQ      = 4,
    parameter int BYTES     = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDW      = $clog2(NREQ),
    localparam int W        = 8 * BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_sdata,
    input  logic              tx_busy,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    // state | meaning
    // IDLE  | no word held; pick a requester and accept its word
    // SEND  | word held; issue the next byte once the transmitter is free
    // WAIT  | byte pulsed; wait for the transmitter to finish it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int BIW = (BYTES > 1) ? $clog2(BYTES) : 1;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BIW-1:0]    byte_idx_q, byte_idx_d;
    logic [W-1:0]      word_q, word_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_sdata_q, tx_sdata_d;
    logic              busy_q, busy_d;

    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    logic [IDW-1:0]    first_k;
    logic [IDW:0]      grant_sum;
    logic [IDW-1:0]    grant;
    logic              any_valid;
    logic [W-1:0]      word_sel;
    logic [7:0]        byte_sel;
    int                byte_shift;

    // Rotate valids so bit 0 is the rr_ptr requester, then find the first set bit.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
        valid_rot = valid_dbl[NREQ-1:0];
        first_k   = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                first_k   = IDW'(k);
                any_valid = 1'b1;
            end
        end
        grant_sum = {1'b0, rr_ptr_q} + {1'b0, first_k};
        if (grant_sum >= (IDW+1)'(NREQ)) begin
            grant_sum = grant_sum - (IDW+1)'(NREQ);
        end
        grant = grant_sum[IDW-1:0];
    end

    always_comb begin
        word_sel   = W'(req_data >> (W * int'(grant)));
        byte_shift = MSB_FIRST ? (W - 8 - 8 * int'(byte_idx_q)) : (8 * int'(byte_idx_q));
        byte_sel   = 8'(word_q >> byte_shift);
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        grant_id_d = grant_id_q;
        tx_start_d = 1'b0;
        tx_sdata_d = tx_sdata_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    word_d     = word_sel;
                    grant_id_d = grant;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_sdata_d = byte_sel;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // tx_busy echoes our own pulse, so the pulse cycle never counts as done.
                if (!tx_start_q && !tx_busy) begin
                    if (byte_idx_q == BIW'(BYTES - 1)) begin
                        rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
                        busy_d   = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            grant_id_q <= '0;
            tx_start_q <= 1'b0;
            tx_sdata_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            grant_id_q <= grant_id_d;
            tx_start_q <= tx_start_d;
            tx_sdata_q <= tx_sdata_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ready = (!reset && state_q == IDLE && any_valid) ? (NREQ'(1) << grant) : '0;
    assign tx_start  = tx_start_q;
    assign tx_sdata  = tx_sdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Directed bench for uart_tx_word_arbiter: round-robin order, byte order, latency,
// transmitter back-pressure and mid-word reset, against a small UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_word_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         tx_start;
    logic [7:0]   tx_sdata;
    logic         tx_busy;
    logic         busy;
    logic [1:0]   grant_id;
    logic         force_busy;
    logic [3:0]   cnt = '0;

    logic [1:0]   m_req_valid;
    logic [63:0]  m_req_data;
    logic [1:0]   m_req_ready;
    logic         m_tx_start;
    logic [7:0]   m_tx_sdata;
    logic         m_tx_busy;
    logic         m_busy;
    logic [0:0]   m_grant_id;
    logic [3:0]   m_cnt = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int onehot_err = 0;
    int pulse_err = 0;
    bit prev_start = 1'b0;
    bit low_seen = 1'b1;
    int          acc_q[$];
    logic [7:0]  byte_q[$];
    int          start_q[$];
    logic [7:0]  m_byte_q[$];

    always #5 clock = ~clock;

    uart_tx_word_arbiter #(.NREQ(4), .BYTES(4), .MSB_FIRST(1'b0)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_sdata(tx_sdata),
        .tx_busy(tx_busy), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_word_arbiter #(.NREQ(2), .BYTES(4), .MSB_FIRST(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .req_valid(m_req_valid), .req_data(m_req_data),
        .req_ready(m_req_ready), .tx_start(m_tx_start), .tx_sdata(m_tx_sdata),
        .tx_busy(m_tx_busy), .busy(m_busy), .grant_id(m_grant_id)
    );

    // UART model: busy during the start pulse and three cycles after it.
    assign tx_busy   = tx_start | (cnt != 0) | force_busy;
    assign m_tx_busy = m_tx_start | (m_cnt != 0);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tx_start) cnt <= 4'd3;
        else if (cnt != 0) cnt <= cnt - 1'b1;
        if (m_tx_start) m_cnt <= 4'd3;
        else if (m_cnt != 0) m_cnt <= m_cnt - 1'b1;
    end

    always @(negedge clock) begin
        if (|(req_valid & req_ready)) begin
            int idx;
            idx = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
            acc_q.push_back(idx);
            acc_cyc = cyc;
            if (!$onehot(req_ready)) onehot_err++;
        end
        if (tx_start === 1'b1) begin
            byte_q.push_back(tx_sdata);
            start_q.push_back(cyc);
            if (prev_start || !low_seen) pulse_err++;
            low_seen = 1'b0;
        end else if (tx_busy === 1'b0) begin
            low_seen = 1'b1;
        end
        prev_start = (tx_start === 1'b1);
        if (m_tx_start === 1'b1) m_byte_q.push_back(m_tx_sdata);
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept(output bit ok);
        int n0, n;
        n0 = acc_q.size();
        n = 0;
        while (acc_q.size() == n0 && n < 300) begin tick(); n++; end
        ok = (acc_q.size() != n0);
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin tick(); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        bit dummy;
        reset = 1'b1; force_busy = 1'b0; req_valid = 4'hF;
        req_data = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
        m_req_valid = 2'b00; m_req_data = '0;
        repeat (3) @(posedge clock);
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
        checks++; if (tx_sdata !== 8'h00) begin errors++; $display("FAIL reset_tx_sdata got %h exp 00", tx_sdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_msb_busy got %b exp 0", m_busy); end
    endtask

    task automatic test_round_robin();
        int exp_rr[5];
        logic [7:0] exp_b[4];
        int n;
        bit ok;
        exp_rr = '{0, 1, 2, 3, 0};
        exp_b  = '{8'h44, 8'h33, 8'h22, 8'h11};
        drive_edge();
        reset = 1'b0;
        acc_q.delete(); byte_q.delete(); start_q.delete(); onehot_err = 0;
        n = 0;
        while (acc_q.size() < 5 && n < 600) begin tick(); n++; end
        drive_edge();
        req_valid = 4'h0;
        checks++;
        if (acc_q.size() < 5) begin
            errors++; $display("FAIL rr_accept_count got %0d exp 5", acc_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (acc_q[i] != exp_rr[i]) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", i, acc_q[i], exp_rr[i]); end
            end
        end
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL rr_onehot got %0d bad accepts exp 0", onehot_err); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_idle got busy=%b exp 0", busy); end
        checks++;
        if (byte_q.size() != 20) begin
            errors++; $display("FAIL rr_byte_count got %0d exp 20", byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (byte_q[16+i] !== exp_b[i]) begin errors++; $display("FAIL rr_last_word_byte[%0d] got %h exp %h", i, byte_q[16+i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_alternate();
        int exp_a[4];
        bit ok;
        exp_a = '{1, 3, 1, 3};
        drive_edge();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_accept(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL alt_accept_timeout[%0d] got none exp grant %0d", k, exp_a[k]);
            end else begin
                checks++;
                if (acc_q[$] != exp_a[k]) begin errors++; $display("FAIL alt_grant[%0d] got %0d exp %0d", k, acc_q[$], exp_a[k]); end
                tick();
                checks++;
                if (grant_id !== 2'(exp_a[k])) begin errors++; $display("FAIL alt_grant_id[%0d] got %0d exp %0d", k, grant_id, exp_a[k]); end
            end
        end
        drive_edge();
        req_valid = 4'h0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL alt_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] exp_b[4];
        int t_acc, t_idle;
        bit ok;
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
        byte_q.delete(); start_q.delete(); pulse_err = 0;
        drive_edge();
        req_valid = 4'b0001;
        req_data[31:0] = 32'h11223344;
        wait_accept(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept_timeout got none exp req 0"); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_req_ready got %b exp 0001", req_ready); end
        t_acc = acc_cyc;
        drive_edge();
        req_valid = 4'h0;
        req_data[31:0] = 32'hDEADBEEF;
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_one_cycle got %b exp 0000", req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
        wait_idle(ok);
        t_idle = cyc;
        checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy); end
        checks++;
        if (byte_q.size() != 4) begin
            errors++; $display("FAIL single_byte_count got %0d exp 4", byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL single_byte[%0d] got %h exp %h", i, byte_q[i], exp_b[i]); end
            end
            checks++; if (start_q[0] != t_acc + 2) begin errors++; $display("FAIL single_first_latency got %0d exp %0d", start_q[0] - t_acc, 2); end
            checks++; if (start_q[1] - start_q[0] != 6) begin errors++; $display("FAIL single_byte_spacing got %0d exp 6", start_q[1] - start_q[0]); end
            checks++; if (t_idle != start_q[3] + 5) begin errors++; $display("FAIL single_idle_latency got %0d exp 5", t_idle - start_q[3]); end
        end
        checks++; if (pulse_err != 0) begin errors++; $display("FAIL single_pulse_rule got %0d violations exp 0", pulse_err); end
        req_data[31:0] = 32'h11223344;
    endtask

    task automatic test_msb_first();
        logic [7:0] exp_b[4];
        int n;
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        m_byte_q.delete();
        drive_edge();
        m_req_valid = 2'b01;
        m_req_data[31:0] = 32'hA1B2C3D4;
        n = 0;
        while (m_req_ready[0] !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (m_req_ready !== 2'b01) begin errors++; $display("FAIL msb_req_ready got %b exp 01", m_req_ready); end
        drive_edge();
        m_req_valid = 2'b00;
        n = 0;
        while (m_busy !== 1'b0 && n < 300) begin tick(); n++; end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL msb_idle got busy=%b exp 0", m_busy); end
        checks++;
        if (m_byte_q.size() != 4) begin
            errors++; $display("FAIL msb_byte_count got %0d exp 4", m_byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (m_byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL msb_byte[%0d] got %h exp %h", i, m_byte_q[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] exp_b[4];
        int seen, drop_cyc;
        bit ok;
        exp_b = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
        byte_q.delete(); start_q.delete();
        drive_edge();
        force_busy = 1'b1;
        req_valid = 4'b0100;
        wait_accept(ok);
        checks++; if (!ok || acc_q[$] != 2) begin errors++; $display("FAIL hold_grant got %0d exp 2", ok ? acc_q[$] : -1); end
        drive_edge();
        req_valid = 4'h0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (tx_start !== 1'b0) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL hold_no_start got %0d pulses exp 0", seen); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", busy); end
        drive_edge();
        force_busy = 1'b0;
        drop_cyc = cyc;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_idle got busy=%b exp 0", busy); end
        checks++;
        if (byte_q.size() != 4) begin
            errors++; $display("FAIL hold_byte_count got %0d exp 4", byte_q.size());
        end else begin
            checks++; if (start_q[0] != drop_cyc + 1) begin errors++; $display("FAIL hold_release_latency got %0d exp 1", start_q[0] - drop_cyc); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL hold_byte[%0d] got %h exp %h", i, byte_q[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_b[4];
        int n;
        bit ok;
        exp_b = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
        byte_q.delete(); start_q.delete();
        drive_edge();
        req_valid = 4'b0100;
        wait_accept(ok);
        checks++; if (!ok || acc_q[$] != 2) begin errors++; $display("FAIL mid_grant got %0d exp 2", ok ? acc_q[$] : -1); end
        drive_edge();
        req_valid = 4'h0;
        n = 0;
        while (start_q.size() < 2 && n < 100) begin tick(); n++; end
        checks++; if (start_q.size() < 2) begin errors++; $display("FAIL mid_second_byte got %0d pulses exp 2", start_q.size()); end
        drive_edge();
        reset = 1'b1;
        drive_edge();
        reset = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start got %b exp 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_req_ready got %b exp 0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant_id got %0d exp 0", grant_id); end
        byte_q.delete(); start_q.delete();
        drive_edge();
        req_valid = 4'b1100;
        wait_accept(ok);
        checks++; if (!ok || acc_q[$] != 2) begin errors++; $display("FAIL mid_rr_ptr_reset got grant %0d exp 2", ok ? acc_q[$] : -1); end
        drive_edge();
        req_valid = 4'h0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_idle got busy=%b exp 0", busy); end
        checks++;
        if (byte_q.size() != 4) begin
            errors++; $display("FAIL mid_byte_count got %0d exp 4", byte_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (byte_q[i] !== exp_b[i]) begin errors++; $display("FAIL mid_byte[%0d] got %h exp %h", i, byte_q[i], exp_b[i]); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_alternate();
        test_single();
        test_msb_first();
        test_busy_hold();
        test_reset_mid_word();
        checks++; if (pulse_err != 0) begin errors++; $display("FAIL pulse_rule got %0d violations exp 0", pulse_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
